// File: rtl/ca_grid_engine.sv
// DEPTH x WIDTH one-bit cellular-automaton history grid with a legacy serial-shift seed path.
// Row 0 is seeded serially or by handshake; rows 1..DEPTH-1 then fill one generation per clock.
module ca_grid_engine #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int BOUNDARY = 0
) (
    input  logic                     FPGA_CLK_50,
    input  logic                     RESET_N,
    input  logic                     MODE,
    input  logic [7:0]               RULE_IN,
    input  logic                     RULE_WE,
    input  logic                     SER_IN,
    output logic                     SER_OUT,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [WIDTH-1:0]         IN_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [WIDTH-1:0]         OUT_DATA,
    input  logic [$clog2(DEPTH)-1:0] ROW_SEL,
    output logic [WIDTH-1:0]         ROW_DATA,
    output logic                     BUSY
);
    localparam int GW = $clog2(DEPTH);
    localparam logic [GW:0]   ROW_LIMIT = (GW + 1)'(DEPTH);
    localparam logic [GW-1:0] LAST_GEN  = GW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] grid [DEPTH];
    logic [7:0]       rule_reg;
    logic [7:0]       active_rule;
    logic [GW-1:0]    gen;
    logic             accept;
    logic             shift_en;
    logic             step_en;
    logic             last_gen;
    logic [WIDTH-1:0] prev_row;
    logic [WIDTH-1:0] next_row;
    logic [WIDTH+1:0] ext;
    logic             lpad;
    logic             rpad;

    assign last_gen = (gen == LAST_GEN);
    assign prev_row = grid[gen - GW'(1)];

    always_ff @(posedge FPGA_CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        shift_en   = 1'b0;
        step_en    = 1'b0;
        case (state)
            IDLE: begin
                if (MODE) begin
                    if (IN_VALID) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end
                end else begin
                    shift_en = 1'b1;
                end
            end
            RUN: begin
                step_en = 1'b1;
                if (last_gen) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pad the previous row with its edge neighbours so each cell's {L,C,R} is a plain 3-bit slice.
    always_comb begin
        lpad     = (BOUNDARY == 0) ? prev_row[0] : 1'b0;
        rpad     = (BOUNDARY == 0) ? prev_row[WIDTH-1] : 1'b0;
        ext      = {lpad, prev_row, rpad};
        next_row = '0;
        for (int i = 0; i < WIDTH; i++) begin
            next_row[i] = active_rule[ext[i +: 3]];
        end
    end

    always_ff @(posedge FPGA_CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int r = 0; r < DEPTH; r++) begin
                grid[r] <= '0;
            end
            rule_reg    <= 8'h00;
            active_rule <= 8'h00;
            gen         <= '0;
        end else begin
            if (RULE_WE) begin
                rule_reg <= RULE_IN;
            end
            if (accept) begin
                grid[0]     <= IN_DATA;
                active_rule <= rule_reg;
                gen         <= GW'(1);
            end
            if (shift_en) begin
                grid[0] <= {grid[0][WIDTH-2:0], SER_IN};
            end
            if (step_en) begin
                grid[gen] <= next_row;
                if (!last_gen) begin
                    gen <= gen + GW'(1);
                end
            end
        end
    end

    always_comb begin
        ROW_DATA = '0;
        if ({1'b0, ROW_SEL} < ROW_LIMIT) begin
            ROW_DATA = grid[ROW_SEL];
        end
    end

    // IN_READY is gated by reset so nothing is offered to the producer while RESET_N is low.
    assign IN_READY  = RESET_N && (state == IDLE) && MODE;
    assign OUT_VALID = (state == DONE);
    assign BUSY      = (state != IDLE);
    assign OUT_DATA  = grid[DEPTH-1];
    assign SER_OUT   = grid[0][WIDTH-1];

endmodule

// File: tb/tb_ca_grid_engine.sv
// Randomised self-checking bench for ca_grid_engine; both edge modes run side by side from
// one stimulus stream and are compared against a rule-table reference model of the grid.
module tb_ca_grid_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [7:0]  rule_in;
    logic        rule_we;
    logic        ser_in;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic [3:0]  row_sel;

    logic        ser_out0, in_ready0, out_valid0, busy0;
    logic [15:0] out_data0, row_data0;
    logic        ser_out1, in_ready1, out_valid1, busy1;
    logic [15:0] out_data1, row_data1;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m0 [16];
    logic [15:0] m1 [16];
    logic [7:0]  m_rule;
    logic [7:0]  m_active;

    always #5 clk = ~clk;

    ca_grid_engine #(.WIDTH(16), .DEPTH(16), .BOUNDARY(0)) dut_wrap (
        .FPGA_CLK_50(clk), .RESET_N(rst_n), .MODE(mode), .RULE_IN(rule_in), .RULE_WE(rule_we),
        .SER_IN(ser_in), .SER_OUT(ser_out0), .IN_VALID(in_valid), .IN_READY(in_ready0),
        .IN_DATA(in_data), .OUT_VALID(out_valid0), .OUT_READY(out_ready), .OUT_DATA(out_data0),
        .ROW_SEL(row_sel), .ROW_DATA(row_data0), .BUSY(busy0)
    );

    ca_grid_engine #(.WIDTH(16), .DEPTH(16), .BOUNDARY(1)) dut_zero (
        .FPGA_CLK_50(clk), .RESET_N(rst_n), .MODE(mode), .RULE_IN(rule_in), .RULE_WE(rule_we),
        .SER_IN(ser_in), .SER_OUT(ser_out1), .IN_VALID(in_valid), .IN_READY(in_ready1),
        .IN_DATA(in_data), .OUT_VALID(out_valid1), .OUT_READY(out_ready), .OUT_DATA(out_data1),
        .ROW_SEL(row_sel), .ROW_DATA(row_data1), .BUSY(busy1)
    );

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // One generation from the rule table: bit {L,C,R} of the rule, L = cell i+1, R = cell i-1.
    function automatic logic [15:0] ca_step(input logic [15:0] row, input logic [7:0] rule, input bit zero_pad);
        logic [15:0] res;
        int l, c, r;
        for (int i = 0; i < 16; i++) begin
            c = int'(row[i]);
            if (i == 15) l = zero_pad ? 0 : int'(row[0]);
            else         l = int'(row[i + 1]);
            if (i == 0)  r = zero_pad ? 0 : int'(row[15]);
            else         r = int'(row[i - 1]);
            res[i] = rule[l * 4 + c * 2 + r];
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < 16; r++) begin
            m0[r] = 16'h0;
            m1[r] = 16'h0;
        end
        m_rule   = 8'h00;
        m_active = 8'h00;
    endtask

    task automatic check_all_rows(input string tag);
        for (int r = 0; r < 16; r++) begin
            row_sel = 4'(r);
            #1;
            check_output($sformatf("%s_wrap_row%0d", tag, r), 32'(row_data0), 32'(m0[r]));
            check_output($sformatf("%s_zero_row%0d", tag, r), 32'(row_data1), 32'(m1[r]));
        end
        check_output({tag, "_wrap_out_data"}, 32'(out_data0), 32'(m0[15]));
        check_output({tag, "_zero_out_data"}, 32'(out_data1), 32'(m1[15]));
    endtask

    task automatic load_rule(input logic [7:0] r);
        tick();
        rule_we = 1'b1;
        rule_in = r;
        tick();
        rule_we = 1'b0;
        m_rule  = r;
    endtask

    // Seed, let the run complete (mid_we < 0 means no mid-run rule write), stall, then hand off.
    task automatic seed_and_run(input logic [15:0] seed, input bit we_on_accept, input logic [7:0] accept_rule,
                                input int mid_we, input logic [7:0] mid_rule, input int stall);
        int cycles;
        tick();
        mode     = 1'b1;
        in_valid = 1'b1;
        in_data  = seed;
        if (we_on_accept) begin
            rule_we = 1'b1;
            rule_in = accept_rule;
        end
        #1;
        check_output("in_ready_idle", 32'(in_ready0), 32'(1));
        check_output("busy_idle", 32'(busy0), 32'(0));
        tick();
        in_valid = 1'b0;
        rule_we  = 1'b0;
        in_data  = 16'($urandom);
        m0[0] = seed;
        m1[0] = seed;
        m_active = m_rule;
        if (we_on_accept) m_rule = accept_rule;
        for (int k = 1; k < 16; k++) begin
            m0[k] = ca_step(m0[k - 1], m_active, 1'b0);
            m1[k] = ca_step(m1[k - 1], m_active, 1'b1);
        end
        if (stall == 0) out_ready = 1'b1;
        cycles = 0;
        while (!out_valid0 && cycles < 40) begin
            check_output("busy_run", 32'({busy0, busy1}), 32'(2'b11));
            check_output("in_ready_run", 32'(in_ready0), 32'(0));
            if (cycles == mid_we) begin
                rule_we = 1'b1;
                rule_in = mid_rule;
                m_rule  = mid_rule;
            end
            mode     = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            ser_in   = 1'($urandom_range(0, 1));
            tick();
            rule_we = 1'b0;
            cycles++;
        end
        mode     = 1'b1;
        in_valid = 1'b0;
        check_output("latency", 32'(cycles), 32'(15));
        check_output("out_valid_done", 32'({out_valid0, out_valid1}), 32'(2'b11));
        check_output("wrap_out_data_done", 32'(out_data0), 32'(m0[15]));
        check_output("zero_out_data_done", 32'(out_data1), 32'(m1[15]));
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            tick();
            check_output("stall_out_valid", 32'(out_valid0), 32'(1));
            check_output("stall_out_data", 32'(out_data0), 32'(m0[15]));
            check_output("stall_in_ready", 32'(in_ready0), 32'(0));
            check_output("stall_busy", 32'(busy0), 32'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_output("out_valid_after_hs", 32'({out_valid0, out_valid1}), 32'(0));
        check_output("busy_after_hs", 32'(busy0), 32'(0));
        check_output("in_ready_after_hs", 32'(in_ready0), 32'(1));
        check_all_rows("run");
    endtask

    task automatic shift_bit(input logic b);
        ser_in  = b;
        row_sel = 4'd0;
        #1;
        check_output("shift_in_ready", 32'({in_ready0, in_ready1}), 32'(0));
        check_output("shift_busy", 32'(busy0), 32'(0));
        tick();
        m0[0] = {m0[0][14:0], b};
        m1[0] = {m1[0][14:0], b};
        check_output("shift_ser_out", 32'({ser_out0, ser_out1}), 32'({m0[0][15], m1[0][15]}));
        check_output("shift_row0", 32'(row_data0), 32'(m0[0]));
        check_output("shift_out_data", 32'(out_data0), 32'(m0[15]));
    endtask

    task automatic apply_stimulus();
        int hi_at;
        // Directed rule 90 run with a 0xCC write mid-run and five cycles of backpressure.
        load_rule(8'h5A);
        seed_and_run(16'h0080, 1'b0, 8'h00, 5, 8'hCC, 5);
        row_sel = 4'd1; #1; check_output("r90_row1", 32'(row_data0), 32'h0140);
        row_sel = 4'd2; #1; check_output("r90_row2", 32'(row_data0), 32'h0220);
        row_sel = 4'd3; #1; check_output("r90_row3", 32'(row_data0), 32'h0550);

        // Identity rule from the register; a write on the accept edge must not be snapshotted.
        seed_and_run(16'hA5C3, 1'b1, 8'h00, -1, 8'h00, 0);
        check_output("identity_out", 32'(out_data0), 32'hA5C3);
        row_sel = 4'd9; #1; check_output("identity_row9", 32'(row_data1), 32'hA5C3);
        seed_and_run(16'hA5C3, 1'b0, 8'h00, -1, 8'h00, 1);
        check_output("rule0_out", 32'(out_data0), 32'h0000);

        load_rule(8'hAA);
        seed_and_run(16'h8000, 1'b0, 8'h00, -1, 8'h00, 2);
        check_output("rule170_wrap_out", 32'(out_data0), 32'h4000);
        check_output("rule170_zero_out", 32'(out_data1), 32'h0000);
        seed_and_run(16'h0001, 1'b0, 8'h00, -1, 8'h00, 0);
        check_output("rule170_lsb_out", 32'(out_data0), 32'h8000);

        for (int it = 0; it < 6; it++) begin
            int mid;
            if ($urandom_range(0, 1) == 1) load_rule(8'($urandom));
            mid = int'($urandom_range(0, 15));
            if (mid == 15) mid = -1;
            seed_and_run(16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), mid, 8'($urandom),
                         int'($urandom_range(0, 4)));
        end

        // Serial shift: a single 1 must reach SER_OUT on the 16th clock after it enters.
        tick();
        mode     = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) shift_bit(1'b0);
        shift_bit(1'b1);
        hi_at = -1;
        for (int i = 1; i <= 18; i++) begin
            shift_bit(1'b0);
            if (ser_out0 && hi_at < 0) hi_at = i;
        end
        check_output("shift_ser_out_delay", 32'(hi_at), 32'(15));
        for (int i = 0; i < 20; i++) shift_bit(1'($urandom_range(0, 1)));
        mode     = 1'b1;
        in_valid = 1'b0;

        // Reset at RUN cycle 7 clears everything, then a fresh run uses rule register 0x00.
        load_rule(8'h5A);
        tick();
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        #1;
        model_clear();
        check_output("rst_run_busy", 32'({busy0, busy1}), 32'(0));
        check_output("rst_run_out_valid", 32'({out_valid0, out_valid1}), 32'(0));
        check_output("rst_run_in_ready", 32'({in_ready0, in_ready1}), 32'(0));
        check_all_rows("rst_run");
        @(negedge clk);
        rst_n = 1'b1;
        seed_and_run(16'($urandom), 1'b0, 8'h00, -1, 8'h00, 1);
        check_output("post_rst_out", 32'(out_data0), 32'h0000);
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b1;
        rule_in   = 8'h00;
        rule_we   = 1'b0;
        ser_in    = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hFFFF;
        out_ready = 1'b0;
        row_sel   = 4'd0;
        model_clear();
        #2;
        check_output("reset_in_ready", 32'({in_ready0, in_ready1}), 32'(0));
        check_output("reset_out_valid", 32'({out_valid0, out_valid1}), 32'(0));
        check_output("reset_busy", 32'({busy0, busy1}), 32'(0));
        check_output("reset_ser_out", 32'({ser_out0, ser_out1}), 32'(0));
        check_all_rows("reset");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ca_grid_engine.md
Name: ca_grid_engine

Overview:
- Parametrised successor to the board-level bit-grid shift chain.
- Holds a DEPTH x WIDTH grid of 1-bit cells. Row 0 is seeded either serially (shift mode, legacy switch-to-LED chain) or in parallel via a valid/ready handshake (CA mode).
- In CA mode, rows 1..DEPTH-1 are filled one generation per clock using a 1-D elementary cellular-automaton rule (8-bit truth table).
- Sits between board I/O (SW/KEY/LED) and the GA evaluation logic, which supplies candidate rules and reads back generation history.

Parameters:
WIDTH, 16, cells per row (>=3)
DEPTH, 16, rows/generations stored, including the seed row (>=2)
BOUNDARY, 0, edge handling: 0 = wrap-around, 1 = zero-padded edges

Ports:
FPGA_CLK_50  in  1  system clock, all state on rising edge
RESET_N  in  1  asynchronous active-low reset
MODE  in  1  0 = serial shift mode, 1 = CA evolve mode
RULE_IN  in  8  rule truth table
RULE_WE  in  1  load RULE_IN into rule register
SER_IN  in  1  serial input into row 0 bit 0 (shift mode)
SER_OUT  out  1  row 0 bit WIDTH-1
IN_VALID  in  1  seed row offered
IN_READY  out  1  engine accepts seed
IN_DATA  in  WIDTH  seed row
OUT_VALID  out  1  final generation available
OUT_READY  in  1  consumer takes final generation
OUT_DATA  out  WIDTH  row DEPTH-1
ROW_SEL  in  clog2(DEPTH)  history row select
ROW_DATA  out  WIDTH  grid[ROW_SEL], combinational; 0 if ROW_SEL>=DEPTH
BUSY  out  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release): all grid cells 0, rule register 0x00, active rule 0x00, gen counter 0, state IDLE. Outputs are 0 while RESET_N is low, including IN_READY, OUT_VALID, SER_OUT and BUSY.
- Rule register: RULE_WE loads RULE_IN on any cycle in any state. The active rule is snapshotted at seed acceptance, so a write mid-run affects only the next run.
- CA next-state for cell i: index = {L,C,R}, where L = prev[i+1], C = prev[i], R = prev[i-1]; new[i] = rule[index].
  - Edges with BOUNDARY=0: prev[WIDTH] = prev[0], prev[-1] = prev[WIDTH-1].
  - Edges with BOUNDARY=1: out-of-range neighbours read as 0.
- FSM states:
  - IDLE: IN_READY = MODE.
    - MODE=1 and IN_VALID&&IN_READY: grid[0] <= IN_DATA, active rule <= rule register, gen <= 1, go to RUN.
    - MODE=0: each cycle grid[0] <= {grid[0][WIDTH-2:0], SER_IN}; other rows unchanged; IN_VALID ignored.
  - RUN: each cycle grid[gen] <= next(grid[gen-1]) and gen++. After writing row DEPTH-1, go to DONE. RUN lasts exactly DEPTH-1 cycles. MODE, SER_IN and IN_VALID are ignored.
  - DONE: OUT_VALID=1; OUT_DATA stable = grid[DEPTH-1]. On OUT_READY, go to IDLE in the same edge. The grid holds its contents until the next seed or shift.
- Latency: the first OUT_VALID cycle begins DEPTH-1 clocks after the seed-accept edge (15 at default). The earliest back-to-back seed is accepted one cycle after the OUT handshake.
- OUT_DATA reads grid[DEPTH-1] in all states. The value is only meaningful when OUT_VALID is high.
- SER_OUT = grid[0][WIDTH-1] in all states.
- Simultaneous events:
  - RULE_WE on the accept edge: the snapshot takes the old register value.
  - OUT_READY held high entering DONE: OUT_VALID is high for exactly one cycle.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with a cleared grid. No OUT_VALID is produced.

Test Plan:
- Rule 0x5A (rule 90), BOUNDARY=0, seed 0x0080 -> ROW_DATA rows 1/2/3 = 0x0140/0x0220/0x0550; OUT_VALID asserted 15 cycles after accept.
- Rule 0xCC (identity), seed 0xA5C3 -> all 16 rows and OUT_DATA = 0xA5C3; rule 0x00 with the same seed -> rows 1..15 = 0x0000.
- Rule 0xAA, seed 0x8000: BOUNDARY=0 -> OUT_DATA 0x4000; BOUNDARY=1 -> OUT_DATA 0x0000. Seed 0x0001 with BOUNDARY=0 -> 0x8000.
- MODE=0, SER_IN=1 for one cycle then 0 -> SER_OUT high exactly on the 16th cycle after, for one cycle; IN_READY=0 throughout.
- Backpressure: OUT_READY low for 5 cycles in DONE -> OUT_VALID/OUT_DATA held, IN_READY=0, BUSY=1. RULE_WE=0xCC during RUN -> current run still uses the snapshotted rule 90 (row 3 = 0x0550).
- RESET_N pulsed low at RUN cycle 7 -> BUSY, OUT_VALID and all ROW_DATA = 0 immediately; next seed runs normally with rule register 0x00.
